multi_cycle_controller: RTL and testbench
=========================================

// Module: multi_cycle_controller
// PURPOSE
//  Moore FSM that sequences the shared MIPS datapath (one ALU, one unified memory, IR, PC) over 3-5 steps per instruction.
//  Replaces the single-cycle decoder for the multi-cycle CPU.
//  Advances only on a one-clock step pulse, derived on-chip from the debounced hand clock or from a free-run enable.
//  Also drives the instruction-type LEDs, an instruction counter and an illegal-opcode flag for the debug display.
// PARAMETERS
//  CNT_W   16  width of instr_count; wraps modulo 2^CNT_W
// PORTS
//  clock        in   1      system clock; all state changes on its rising edge
//  reset        in   1      asynchronous, active-low; 0 forces reset state immediately
//  hand_clock   in   1      debounced hand clock level, sampled by clock
//  free_run     in   1      1: step every clock cycle; 0: step on hand_clock rising edge only
//  opcode       in   6      IR[31:26] (IR output, stable after FETCH)
//  alu_zero     in   1      ALU zero flag
//  pc_write     out  1      PC load enable (qualified by step)
//  pc_write_cond out 1      PC load enable if alu_zero (qualified by step)
//  i_or_d       out  1      memory address select: 0=PC, 1=ALUOut
//  mem_write    out  1      memory write enable (qualified by step)
//  ir_write     out  1      IR load enable (qualified by step)
//  mem_to_reg   out  1      register write data select: 0=ALUOut, 1=MDR
//  reg_dst      out  1      register write address select: 0=rt, 1=rd
//  reg_write    out  1      GPR write enable (qualified by step)
//  alu_src_a    out  1      0=PC, 1=rs
//  alu_src_b    out  2      00=rt, 01=4, 10=signext, 11=signext<<2
//  alu_op       out  2      00=add, 01=sub, 10=funct (to aluc)
//  pc_source    out  2      00=ALU result, 01=ALUOut, 10=jump target
//  state        out  4      current state encoding (debug)
//  type_led     out  5      {R,LW,SW,BEQ,J}, one-hot or 0
//  illegal      out  1      sticky flag for undefined opcode
//  instr_count  out  CNT_W  completed instructions
// BEHAVIOUR
//  step = free_run | (hand_clock & ~hand_clock_q); hand_clock_q is registered every clock. State, counters and flags update only when step=1.
//  Write enables (pc_write, pc_write_cond, mem_write, ir_write, reg_write) = state decode AND step; all other outputs are pure state decode.
//  States and encodings:
//   FETCH 0 -> DECODE 1
//   DECODE -> MEMADR 2 (lw/sw); EXEC 6 (R); BRANCH 8 (beq); JUMP 9 (j); ADDIEX 10 (addi); FETCH (any other opcode)
//   MEMADR -> MEMRD 3 (lw) / MEMWR 5 (sw); MEMRD -> MEMWB 4; EXEC -> ALUWB 7; ADDIEX -> ADDIWB 11
//   MEMWB, MEMWR, ALUWB, BRANCH, JUMP, ADDIWB -> FETCH. Encodings 12-15 -> FETCH, all outputs 0.
//  Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
//  Per-state outputs (unlisted outputs 0):
//   FETCH: i_or_d=0, ir_write, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, pc_write
//   DECODE: alu_src_a=0, alu_src_b=11, alu_op=00
//   MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00
//   MEMRD: i_or_d=1
//   MEMWB: reg_dst=0, mem_to_reg=1, reg_write
//   MEMWR: i_or_d=1, mem_write
//   EXEC: alu_src_a=1, alu_src_b=00, alu_op=10
//   ALUWB: reg_dst=1, mem_to_reg=0, reg_write
//   ADDIWB: reg_dst=0, mem_to_reg=0, reg_write
//   BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond
//   JUMP: pc_source=10, pc_write
//  type_led: loaded from opcode on a DECODE step and held until the next DECODE step; 0 for addi and illegal opcodes.
//  illegal: set on a DECODE step with an undefined opcode; cleared only by reset. That DECODE cycle asserts no write enables.
//  instr_count: +1 on each step taken out of a terminal state (MEMWB, MEMWR, ALUWB, BRANCH, JUMP, ADDIWB); FFFF -> 0000. Illegal opcodes are not counted.
//  Reset (reset=0, asynchronous): state=FETCH, hand_clock_q=1, type_led=0, illegal=0, instr_count=0.
//   Setting hand_clock_q=1 blocks a false step if hand_clock is high at release.
//   Reset mid-instruction abandons the instruction with no partial write.
//   With step=0 after reset, all write enables are 0.
//  No handshake with memory: memory is single-cycle async-read, so one step covers one memory access.
// STRUCTURE
//  Shared package mc_defs.vh: state encodings (S_FETCH .. S_ADDIWB), opcode constants, alu_src_b/alu_op/pc_source codes.
//  One sub-module: step_gen (hand-clock edge detector plus free_run OR) producing step. FSM and output decode stay in this module.
// TESTING
//  1. Reset with hand_clock=1, release, hold hand_clock=1 for 10 clocks -> state stays 0, no write enable ever asserted.
//  2. free_run=1, opcode=100011 -> states 0,1,2,3,4,0; reg_write=1 only in state 4 with mem_to_reg=1; instr_count 0->1; type_led=01000.
//  3. free_run=1, opcode=000100: alu_zero=1 in state 8 -> pc_write_cond=1, pc_source=01; repeat with alu_zero=0 -> same path; cycle takes 3 steps.
//  4. opcode=111111 at DECODE -> next state 0, illegal=1 and stays 1, instr_count unchanged, no write enables in DECODE.
//  5. Hand-step mode with opcode=000000: 5 hand_clock pulses -> states 0,1,6,7,0; 3 extra clocks per pulse give no advance.
//     Pull reset low in state 6 -> state=0 at once, type_led=0.
//  6. Preload instr_count to FFFF (force), run one sw (0,1,2,5,0) -> instr_count=0000; mem_write=1 only in state 5.

Source files
------------

// File: rtl/multi_cycle_controller_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encodings,
// opcodes, datapath select codes and opcode classification helpers.
package multi_cycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // LED order is {R, LW, SW, BEQ, J}; addi and undefined opcodes light nothing
    function automatic logic [4:0] type_led_of(input logic [5:0] op);
        case (op)
            OP_RTYPE: return 5'b10000;
            OP_LW:    return 5'b01000;
            OP_SW:    return 5'b00100;
            OP_BEQ:   return 5'b00010;
            OP_J:     return 5'b00001;
            default:  return 5'b00000;
        endcase
    endfunction

    function automatic logic opcode_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Controller <-> datapath/debug bundle. The controller is the master side;
// alu_zero travels with the bus but is consumed by the datapath's PC gating.
interface multi_cycle_controller_if #(
    parameter int unsigned CNT_W = 16
);
    logic [5:0]       opcode;
    logic             alu_zero;
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic [3:0]       state;
    logic [4:0]       type_led;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode,
        output pc_write, pc_write_cond, i_or_d, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, state, type_led, illegal, instr_count
    );

    modport slave (
        output opcode, alu_zero,
        input  pc_write, pc_write_cond, i_or_d, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, state, type_led, illegal, instr_count
    );
endinterface

// File: rtl/multi_cycle_controller_step_gen.sv
// Step pulse generator: rising-edge detect on the debounced hand clock,
// overridden by free-run mode.
module multi_cycle_controller_step_gen (
    input  logic clock,
    input  logic reset,
    input  logic hand_clock,
    input  logic free_run,
    output logic step
);
    logic hand_clock_q;

    // Resets high so a hand clock already held high at release is not an edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) hand_clock_q <= 1'b1;
        else        hand_clock_q <= hand_clock;
    end

    assign step = free_run | (hand_clock & ~hand_clock_q);
endmodule

// File: rtl/multi_cycle_controller.sv
// Moore FSM sequencing the shared multi-cycle MIPS datapath, one state per
// step pulse, plus type LEDs, illegal-opcode flag and instruction counter.
module multi_cycle_controller
    import multi_cycle_controller_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      hand_clock,
    input  logic                      free_run,
    multi_cycle_controller_if.master  bus
);
    logic             step;
    state_e           state_q, state_d;
    logic [4:0]       type_led_q, type_led_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    ctrl_t            dec;
    logic             terminal;

    multi_cycle_controller_step_gen u_step_gen (
        .clock      (clock),
        .reset      (reset),
        .hand_clock (hand_clock),
        .free_run   (free_run),
        .step       (step)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_FETCH;
            type_led_q    <= '0;
            illegal_q     <= 1'b0;
            instr_count_q <= '0;
        end else if (step) begin
            state_q       <= state_d;
            type_led_q    <= type_led_d;
            illegal_q     <= illegal_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d  = S_FETCH;
        dec      = '0;
        terminal = 1'b0;
        case (state_q)
            S_FETCH: begin
                dec.ir_write  = 1'b1;
                dec.pc_write  = 1'b1;
                dec.alu_src_b = SRCB_FOUR;
                dec.alu_op    = ALUOP_ADD;
                dec.pc_source = PCSRC_ALU;
                state_d       = S_DECODE;
            end
            S_DECODE: begin
                dec.alu_src_b = SRCB_BOFF;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = SRCB_IMM;
                state_d       = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_ADDIEX: begin
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = SRCB_IMM;
                state_d       = S_ADDIWB;
            end
            S_MEMRD: begin
                dec.i_or_d = 1'b1;
                state_d    = S_MEMWB;
            end
            S_MEMWB: begin
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                terminal       = 1'b1;
            end
            S_MEMWR: begin
                dec.i_or_d    = 1'b1;
                dec.mem_write = 1'b1;
                terminal      = 1'b1;
            end
            S_EXEC: begin
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = SRCB_RT;
                dec.alu_op    = ALUOP_FUNCT;
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                dec.reg_dst   = 1'b1;
                dec.reg_write = 1'b1;
                terminal      = 1'b1;
            end
            S_ADDIWB: begin
                dec.reg_write = 1'b1;
                terminal      = 1'b1;
            end
            S_BRANCH: begin
                dec.alu_src_a     = 1'b1;
                dec.alu_src_b     = SRCB_RT;
                dec.alu_op        = ALUOP_SUB;
                dec.pc_source     = PCSRC_ALUOUT;
                dec.pc_write_cond = 1'b1;
                terminal          = 1'b1;
            end
            S_JUMP: begin
                dec.pc_source = PCSRC_JUMP;
                dec.pc_write  = 1'b1;
                terminal      = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        type_led_d    = type_led_q;
        illegal_d     = illegal_q;
        instr_count_d = instr_count_q;
        if (state_q == S_DECODE) begin
            type_led_d = type_led_of(bus.opcode);
            if (!opcode_legal(bus.opcode)) illegal_d = 1'b1;
        end
        if (terminal) instr_count_d = instr_count_q + CNT_W'(1);
    end

    // Write enables fire only on the step so a held state never repeats a write
    assign bus.pc_write      = dec.pc_write & step;
    assign bus.pc_write_cond = dec.pc_write_cond & step;
    assign bus.mem_write     = dec.mem_write & step;
    assign bus.ir_write      = dec.ir_write & step;
    assign bus.reg_write     = dec.reg_write & step;
    assign bus.i_or_d        = dec.i_or_d;
    assign bus.mem_to_reg    = dec.mem_to_reg;
    assign bus.reg_dst       = dec.reg_dst;
    assign bus.alu_src_a     = dec.alu_src_a;
    assign bus.alu_src_b     = dec.alu_src_b;
    assign bus.alu_op        = dec.alu_op;
    assign bus.pc_source     = dec.pc_source;
    assign bus.state         = state_q;
    assign bus.type_led      = type_led_q;
    assign bus.illegal       = illegal_q;
    assign bus.instr_count   = instr_count_q;
endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench for multi_cycle_controller: an instruction-path model
// predicts every cycle's outputs; a negedge monitor pops and compares.
module tb_multi_cycle_controller;
    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic [3:0]       st;
        logic [14:0]      ctrl;
        logic [4:0]       led;
        logic             ill;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic hand_clock = 1'b1;
    logic free_run = 1'b0;

    multi_cycle_controller_if #(.CNT_W(CNT_W)) bus ();

    multi_cycle_controller #(.CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .hand_clock (hand_clock),
        .free_run   (free_run),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: the state sequence of the current instruction
    int          path[$];
    int          idx;
    logic        hand_prev;
    logic [4:0]  m_led;
    logic        m_ill;
    int unsigned m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void load_path(input logic [5:0] op);
        case (op)
            6'b100011: path = '{0, 1, 2, 3, 4};
            6'b101011: path = '{0, 1, 2, 5};
            6'b000000: path = '{0, 1, 6, 7};
            6'b000100: path = '{0, 1, 8};
            6'b000010: path = '{0, 1, 9};
            6'b001000: path = '{0, 1, 10, 11};
            default:   path = '{0, 1};
        endcase
    endfunction

    function automatic logic [4:0] led_for(input logic [5:0] op);
        case (op)
            6'b000000: return 5'b10000;
            6'b100011: return 5'b01000;
            6'b101011: return 5'b00100;
            6'b000100: return 5'b00010;
            6'b000010: return 5'b00001;
            default:   return 5'b00000;
        endcase
    endfunction

    // {pw, pwc, iord, mw, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc}
    function automatic logic [14:0] exp_ctrl(input int st, input logic stp);
        logic pw, pwc, iord, mw, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
        {pw, pwc, iord, mw, irw, m2r, rdst, rw, srca} = '0;
        srcb = 2'b00; aluop = 2'b00; pcsrc = 2'b00;
        case (st)
            0:      begin irw = stp; pw = stp; srcb = 2'b01; end
            1:      srcb = 2'b11;
            2, 10:  begin srca = 1'b1; srcb = 2'b10; end
            3:      iord = 1'b1;
            4:      begin m2r = 1'b1; rw = stp; end
            5:      begin iord = 1'b1; mw = stp; end
            6:      begin srca = 1'b1; aluop = 2'b10; end
            7:      begin rdst = 1'b1; rw = stp; end
            11:     rw = stp;
            8:      begin srca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; pwc = stp; end
            9:      begin pcsrc = 2'b10; pw = stp; end
            default: ;
        endcase
        return {pw, pwc, iord, mw, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc};
    endfunction

    function automatic void model_reset();
        path      = '{0, 1};
        idx       = 0;
        hand_prev = 1'b1;
        m_led     = '0;
        m_ill     = 1'b0;
        m_cnt     = 0;
    endfunction

    function automatic exp_t expect_now(input logic stp);
        exp_t e;
        e.st   = 4'(path[idx]);
        e.ctrl = exp_ctrl(path[idx], stp);
        e.led  = m_led;
        e.ill  = m_ill;
        e.cnt  = CNT_W'(m_cnt);
        return e;
    endfunction

    task automatic tick(input logic h, input logic fr, input logic [5:0] op, input logic az);
        logic stp;
        @(posedge clock);
        #1;
        reset = 1'b1;
        hand_clock = h;
        free_run = fr;
        bus.opcode = op;
        bus.alu_zero = az;
        stp = fr | (h & ~hand_prev);
        sb.push_back(expect_now(stp));
        hand_prev = h;
        if (stp) begin
            if (path[idx] == 1) begin
                load_path(op);
                m_led = led_for(op);
                if (path.size() == 2) m_ill = 1'b1;
            end
            idx++;
            if (idx == path.size()) begin
                if (path.size() > 2) m_cnt = (m_cnt + 1) % (1 << CNT_W);
                idx  = 0;
                path = '{0, 1};
            end
        end
    endtask

    task automatic do_reset(input logic h);
        @(posedge clock);
        #1;
        reset = 1'b0;
        hand_clock = h;
        free_run = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
    endtask

    // Asynchronous reset mid-cycle; the monitor checks the effect before the next edge
    task automatic reset_now();
        @(posedge clock);
        #1;
        reset = 1'b0;
        free_run = 1'b0;
        model_reset();
        sb.push_back(expect_now(1'b0));
        repeat (2) @(posedge clock);
    endtask

    task automatic hand_pulse(input logic [5:0] op);
        tick(1'b1, 1'b0, op, 1'b0);
        repeat (3) tick(1'b1, 1'b0, op, 1'b0);
        tick(1'b0, 1'b0, op, 1'b0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("state", 32'(bus.state), 32'(e.st));
                chk("ctrl", 32'({bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_write,
                                 bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
                                 bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source}),
                    32'(e.ctrl));
                chk("type_led", 32'(bus.type_led), 32'(e.led));
                chk("illegal", 32'(bus.illegal), 32'(e.ill));
                chk("instr_count", 32'(bus.instr_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        logic [5:0] ops[8];
        logic [5:0] cur_op;
        int guard;
        bus.opcode = 6'b100011;
        bus.alu_zero = 1'b0;

        // Hand clock high across reset release must not produce a step
        do_reset(1'b1);
        repeat (10) tick(1'b1, 1'b0, 6'b100011, 1'b0);

        // Free-run lw, beq taken / not taken, illegal opcode
        repeat (5) tick(1'b0, 1'b1, 6'b100011, 1'b0);
        repeat (3) tick(1'b0, 1'b1, 6'b000100, 1'b1);
        repeat (3) tick(1'b0, 1'b1, 6'b000100, 1'b0);
        repeat (2) tick(1'b0, 1'b1, 6'b111111, 1'b0);
        repeat (2) tick(1'b0, 1'b0, 6'b111111, 1'b0);

        // Hand-step R-type, then reset while in EXEC
        repeat (5) hand_pulse(6'b000000);
        guard = 0;
        while (path[idx] != 6 && guard < 10) begin
            hand_pulse(6'b000000);
            guard++;
        end
        chk("reach_exec", 32'(path[idx]), 32'd6);
        reset_now();

        // sw in free-run
        repeat (4) tick(1'b0, 1'b1, 6'b101011, 1'b0);
        tick(1'b0, 1'b0, 6'b101011, 1'b0);

        // Random mix; long enough for the counter to wrap several times
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                6'b000010, 6'b001000, 6'b000000, 6'b100011};
        cur_op = 6'b000010;
        for (int i = 0; i < 4000; i++) begin
            if (path[idx] == 0) begin
                if ($urandom_range(0, 7) == 0) cur_op = 6'($urandom_range(0, 63));
                else cur_op = ops[$urandom_range(0, 7)];
            end
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cur_op,
                 1'($urandom_range(0, 1)));
        end

        @(negedge clock);
        #1;
        chk("drain", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
